// File: rtl/commit_unit.sv
// commit_unit: multi-wide in-order retirement stage between the ROB head and
// architectural state (regfile, CC, data memory, fetch redirect).
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   valid_in          per-slot completed-entry flag (slot 0 = ROB head)
//   opcode_in         per-slot lc3b opcode (4 bits each)
//   dest_in           per-slot dest register; nzp mask for branches
//   value_in          per-slot result; target PC for branches
//   predict_in        per-slot predicted-taken bit
//   rob_empty         ROB holds no entries
//   dmem_resp         data memory store completion
//   rf_we             per-slot regfile write strobe
//   rf_busy_clr       per-slot busy-bit clear strobe
//   rf_dest/rf_value  pass-through of dest_in/value_in
//   rob_re_count      number of entries popped this cycle
//   ldstr_re          pop one ld/str buffer entry
//   dmem_write        store request, held until dmem_resp
//   flush/pcmux_sel   squash speculative state and redirect fetch
//   new_pc            redirect target
//   cc_out            architectural nzp
//
// Retirement strobes are combinational from the current state and ROB head so
// the ROB can pop in the same cycle; state and CC are registered.
module commit_unit #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned TAG_WIDTH    = 3,
    parameter int unsigned COMMIT_WIDTH = 2
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic [COMMIT_WIDTH-1:0]              valid_in,
    input  logic [4*COMMIT_WIDTH-1:0]            opcode_in,
    input  logic [3*COMMIT_WIDTH-1:0]            dest_in,
    input  logic [DATA_WIDTH*COMMIT_WIDTH-1:0]   value_in,
    input  logic [COMMIT_WIDTH-1:0]              predict_in,
    input  logic                                 rob_empty,
    input  logic                                 dmem_resp,
    output logic [COMMIT_WIDTH-1:0]              rf_we,
    output logic [COMMIT_WIDTH-1:0]              rf_busy_clr,
    output logic [3*COMMIT_WIDTH-1:0]            rf_dest,
    output logic [DATA_WIDTH*COMMIT_WIDTH-1:0]   rf_value,
    output logic [$clog2(COMMIT_WIDTH+1)-1:0]    rob_re_count,
    output logic                                 ldstr_re,
    output logic                                 dmem_write,
    output logic                                 flush,
    output logic                                 pcmux_sel,
    output logic [DATA_WIDTH-1:0]                new_pc,
    output logic [2:0]                           cc_out
);

    localparam int unsigned CNT_W = $clog2(COMMIT_WIDTH + 1);

    localparam logic [3:0] OP_BR  = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_JSR = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_LDR = 4'd6;
    localparam logic [3:0] OP_STR = 4'd7;
    localparam logic [3:0] OP_NOT = 4'd9;
    localparam logic [3:0] OP_SHF = 4'd13;
    localparam logic [3:0] OP_LEA = 4'd14;

    // Parameter sanity check; the tag width only sizes neighbouring buffers.
    if (COMMIT_WIDTH < 1 || COMMIT_WIDTH > 4 || TAG_WIDTH < 1) begin : g_bad_params
        $error("commit_unit: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        STORE_WAIT = 2'd1,
        FLUSH      = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [2:0]              cc_q, cc_d;

    logic [2:0]              cc_chain;
    logic                    stop;
    logic                    taken;
    logic [CNT_W-1:0]        cnt;
    logic [3:0]              slot_op;
    logic [2:0]              slot_dest;
    logic [DATA_WIDTH-1:0]   slot_value;

    function automatic logic [2:0] gencc(input logic [DATA_WIDTH-1:0] v);
        if (v[DATA_WIDTH-1]) begin
            return 3'b100;
        end else if (v == '0) begin
            return 3'b010;
        end else begin
            return 3'b001;
        end
    endfunction

    // State and architectural CC registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cc_q    <= 3'b010;
        end else begin
            state_q <= state_d;
            cc_q    <= cc_d;
        end
    end

    // Retirement scan, next state and strobes; strobes are forced low during reset.
    always_comb begin
        state_d      = state_q;
        cc_d         = cc_q;
        rf_we        = '0;
        rf_busy_clr  = '0;
        rob_re_count = '0;
        ldstr_re     = 1'b0;
        dmem_write   = 1'b0;
        flush        = 1'b0;
        pcmux_sel    = 1'b0;
        new_pc       = '0;
        cc_chain     = cc_q;
        stop         = 1'b0;
        taken        = 1'b0;
        cnt          = '0;
        slot_op      = '0;
        slot_dest    = '0;
        slot_value   = '0;

        if (reset_n) begin
            unique case (state_q)
                IDLE: begin
                    if (!rob_empty) begin
                        for (int i = 0; i < COMMIT_WIDTH; i++) begin
                            slot_op    = opcode_in[4*i +: 4];
                            slot_dest  = dest_in[3*i +: 3];
                            slot_value = value_in[DATA_WIDTH*i +: DATA_WIDTH];
                            if (!stop) begin
                                if (!valid_in[i]) begin
                                    stop = 1'b1;
                                end else begin
                                    case (slot_op)
                                        OP_ADD, OP_AND, OP_NOT, OP_SHF, OP_LEA, OP_LDR: begin
                                            rf_we[i]       = 1'b1;
                                            rf_busy_clr[i] = 1'b1;
                                            cnt            = cnt + CNT_W'(1);
                                            cc_chain       = gencc(slot_value);
                                        end
                                        OP_JSR: begin
                                            rf_we[i]       = 1'b1;
                                            rf_busy_clr[i] = 1'b1;
                                            cnt            = cnt + CNT_W'(1);
                                        end
                                        OP_BR: begin
                                            // Resolve against CC as left by earlier slots this cycle.
                                            taken = |(slot_dest & cc_chain);
                                            cnt   = cnt + CNT_W'(1);
                                            stop  = 1'b1;
                                            if (taken != predict_in[i]) begin
                                                flush     = 1'b1;
                                                pcmux_sel = 1'b1;
                                                new_pc    = slot_value;
                                                state_d   = FLUSH;
                                            end
                                        end
                                        OP_STR: begin
                                            // Only the head may start a store; later ones wait a cycle.
                                            stop = 1'b1;
                                            if (i == 0) begin
                                                dmem_write = 1'b1;
                                                state_d    = STORE_WAIT;
                                            end
                                        end
                                        default: stop = 1'b1;
                                    endcase
                                end
                            end
                        end
                        cc_d         = cc_chain;
                        rob_re_count = cnt;
                    end
                end
                STORE_WAIT: begin
                    dmem_write = 1'b1;
                    if (dmem_resp) begin
                        rob_re_count = CNT_W'(1);
                        ldstr_re     = 1'b1;
                        state_d      = IDLE;
                    end
                end
                FLUSH: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign rf_dest  = dest_in;
    assign rf_value = value_in;
    assign cc_out   = cc_q;

endmodule

// File: tb/tb_commit_unit.sv
module tb_commit_unit;

    localparam int unsigned DW   = 16;
    localparam int unsigned TW   = 3;
    localparam int unsigned CW   = 2;
    localparam int unsigned CNTW = $clog2(CW + 1);

    localparam logic [3:0] OP_BR  = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_JSR = 4'd4;
    localparam logic [3:0] OP_AND = 4'd5;
    localparam logic [3:0] OP_LDR = 4'd6;
    localparam logic [3:0] OP_STR = 4'd7;
    localparam logic [3:0] OP_NOT = 4'd9;
    localparam logic [3:0] OP_SHF = 4'd13;
    localparam logic [3:0] OP_LEA = 4'd14;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [CW-1:0]        valid_in;
    logic [4*CW-1:0]      opcode_in;
    logic [3*CW-1:0]      dest_in;
    logic [DW*CW-1:0]     value_in;
    logic [CW-1:0]        predict_in;
    logic                 rob_empty;
    logic                 dmem_resp;
    logic [CW-1:0]        rf_we;
    logic [CW-1:0]        rf_busy_clr;
    logic [3*CW-1:0]      rf_dest;
    logic [DW*CW-1:0]     rf_value;
    logic [CNTW-1:0]      rob_re_count;
    logic                 ldstr_re;
    logic                 dmem_write;
    logic                 flush;
    logic                 pcmux_sel;
    logic [DW-1:0]        new_pc;
    logic [2:0]           cc_out;

    commit_unit #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .COMMIT_WIDTH(CW)) dut (
        .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .opcode_in(opcode_in),
        .dest_in(dest_in), .value_in(value_in), .predict_in(predict_in),
        .rob_empty(rob_empty), .dmem_resp(dmem_resp), .rf_we(rf_we),
        .rf_busy_clr(rf_busy_clr), .rf_dest(rf_dest), .rf_value(rf_value),
        .rob_re_count(rob_re_count), .ldstr_re(ldstr_re), .dmem_write(dmem_write),
        .flush(flush), .pcmux_sel(pcmux_sel), .new_pc(new_pc), .cc_out(cc_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 = accepting retirements, 1 = waiting on a store, 2 = flush bubble.
    int          m_mode;
    logic [2:0]  m_cc;
    logic [CW-1:0] e_we;
    int          e_cnt;
    logic        e_ldstr, e_dw, e_flush;
    logic [DW-1:0] e_pc;
    int          e_next_mode;
    logic [2:0]  e_next_cc;

    function automatic logic [2:0] flags_of(input logic [DW-1:0] v);
        if (v == 16'h0000) return 3'b010;
        if (v >= 16'h8000) return 3'b100;
        return 3'b001;
    endfunction

    task automatic model_eval();
        logic [2:0] cc;
        logic [3:0] op;
        bit         done;
        e_we = '0; e_cnt = 0; e_ldstr = 1'b0; e_dw = 1'b0; e_flush = 1'b0; e_pc = '0;
        e_next_mode = m_mode; e_next_cc = m_cc;
        if (!reset_n) begin
            e_next_mode = 0;
            e_next_cc   = 3'b010;
        end else if (m_mode == 2) begin
            e_next_mode = 0;
        end else if (m_mode == 1) begin
            e_dw = 1'b1;
            if (dmem_resp) begin
                e_cnt = 1; e_ldstr = 1'b1; e_next_mode = 0;
            end
        end else if (!rob_empty) begin
            cc = m_cc;
            done = 1'b0;
            for (int k = 0; k < CW; k++) begin
                op = opcode_in[4*k +: 4];
                if (done) begin
                end else if (!valid_in[k]) begin
                    done = 1'b1;
                end else if (op inside {OP_ADD, OP_AND, OP_NOT, OP_SHF, OP_LEA, OP_LDR}) begin
                    e_we[k] = 1'b1; e_cnt++; cc = flags_of(value_in[DW*k +: DW]);
                end else if (op == OP_JSR) begin
                    e_we[k] = 1'b1; e_cnt++;
                end else if (op == OP_BR) begin
                    e_cnt++; done = 1'b1;
                    if ((|(dest_in[3*k +: 3] & cc)) != predict_in[k]) begin
                        e_flush = 1'b1; e_pc = value_in[DW*k +: DW]; e_next_mode = 2;
                    end
                end else if (op == OP_STR && k == 0) begin
                    e_dw = 1'b1; e_next_mode = 1; done = 1'b1;
                end else begin
                    done = 1'b1;
                end
            end
            e_next_cc = cc;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        model_eval();
        chk({tag, ".rf_we"}, 32'(rf_we), 32'(e_we));
        chk({tag, ".rf_busy_clr"}, 32'(rf_busy_clr), 32'(e_we));
        chk({tag, ".rf_dest"}, 32'(rf_dest), 32'(dest_in));
        chk({tag, ".rf_value"}, 32'(rf_value), 32'(value_in));
        chk({tag, ".rob_re_count"}, 32'(rob_re_count), 32'(e_cnt));
        chk({tag, ".ldstr_re"}, 32'(ldstr_re), 32'(e_ldstr));
        chk({tag, ".dmem_write"}, 32'(dmem_write), 32'(e_dw));
        chk({tag, ".flush"}, 32'(flush), 32'(e_flush));
        chk({tag, ".pcmux_sel"}, 32'(pcmux_sel), 32'(e_flush));
        if (e_flush) chk({tag, ".new_pc"}, 32'(new_pc), 32'(e_pc));
        chk({tag, ".cc_out"}, 32'(cc_out), 32'(m_cc));
    endtask

    task automatic settle(input string tag);
        #2;
        check_all(tag);
    endtask

    task automatic advance();
        @(posedge clk);
        m_mode = e_next_mode;
        m_cc   = e_next_cc;
        @(negedge clk);
    endtask

    task automatic set_slot(input int k, input bit v, input logic [3:0] op,
                            input logic [2:0] d, input logic [DW-1:0] val, input bit p);
        valid_in[k]          = v;
        opcode_in[4*k +: 4]  = op;
        dest_in[3*k +: 3]    = d;
        value_in[DW*k +: DW] = val;
        predict_in[k]        = p;
    endtask

    function automatic logic [3:0] rand_op();
        case ($urandom_range(0, 9))
            0: return OP_ADD;
            1: return OP_AND;
            2: return OP_NOT;
            3: return OP_SHF;
            4: return OP_LEA;
            5: return OP_LDR;
            6: return OP_JSR;
            7: return OP_BR;
            8: return OP_STR;
            default: return 4'($urandom_range(0, 15));
        endcase
    endfunction

    function automatic logic [DW-1:0] rand_val();
        case ($urandom_range(0, 3))
            0: return '0;
            1: return 16'h8000 | DW'($urandom);
            default: return DW'($urandom);
        endcase
    endfunction

    initial begin
        m_mode = 0; m_cc = 3'b010;
        reset_n = 1'b0; rob_empty = 1'b0; dmem_resp = 1'b0;
        valid_in = '0; opcode_in = '0; dest_in = '0; value_in = '0; predict_in = '0;
        set_slot(0, 1, OP_ADD, 3'd1, 16'h1234, 0);
        set_slot(1, 1, OP_STR, 3'd2, 16'h0000, 0);
        @(negedge clk);
        // Reset holds every strobe low even with a retirable head.
        settle("reset");
        chk("reset.cc_const", 32'(cc_out), 32'h2);
        chk("reset.rf_we_const", 32'(rf_we), 32'h0);
        advance();
        reset_n = 1'b1;

        // Two adds retire together; CC takes the last value's flags.
        set_slot(0, 1, OP_ADD, 3'd1, 16'h0000, 0);
        set_slot(1, 1, OP_ADD, 3'd2, 16'hFFFE, 0);
        settle("addadd");
        chk("addadd.we_const", 32'(rf_we), 32'h3);
        chk("addadd.cnt_const", 32'(rob_re_count), 32'h2);
        advance();
        valid_in = '0;
        settle("addadd_cc");
        chk("addadd.cc_const", 32'(cc_out), 32'h4);
        advance();

        // Branch resolved on CC chained from the add ahead of it: mispredict.
        set_slot(0, 1, OP_ADD, 3'd3, 16'h0005, 0);
        set_slot(1, 1, OP_BR, 3'b010, 16'h3000, 1);
        settle("mispred");
        chk("mispred.flush_const", 32'(flush), 32'h1);
        chk("mispred.pc_const", 32'(new_pc), 32'h3000);
        chk("mispred.cnt_const", 32'(rob_re_count), 32'h2);
        advance();
        set_slot(0, 1, OP_ADD, 3'd1, 16'h0001, 0);
        set_slot(1, 1, OP_ADD, 3'd2, 16'h0002, 0);
        settle("flush_bubble");
        chk("flush_bubble.cnt_const", 32'(rob_re_count), 32'h0);
        chk("flush_bubble.we_const", 32'(rf_we), 32'h0);
        advance();
        valid_in = '0;
        settle("post_flush");
        chk("post_flush.cc_const", 32'(cc_out), 32'h1);
        advance();

        // Store with three cycles of no response, then completion.
        set_slot(0, 1, OP_STR, 3'd0, 16'h0000, 0);
        set_slot(1, 1, OP_ADD, 3'd4, 16'h0007, 0);
        for (int c = 0; c < 4; c++) begin
            dmem_resp = (c == 3);
            settle("store");
            chk("store.dw_const", 32'(dmem_write), 32'h1);
            chk("store.cnt_const", 32'(rob_re_count), 32'(c == 3));
            advance();
        end
        dmem_resp = 1'b0;
        valid_in = '0;
        settle("store_done");
        chk("store_done.dw_const", 32'(dmem_write), 32'h0);
        advance();

        // JSR retires, store behind it waits; response in the request cycle is ignored.
        set_slot(0, 1, OP_JSR, 3'd7, 16'h4000, 0);
        set_slot(1, 1, OP_STR, 3'd0, 16'h0000, 0);
        settle("jsr_str");
        chk("jsr_str.cnt_const", 32'(rob_re_count), 32'h1);
        chk("jsr_str.dw_const", 32'(dmem_write), 32'h0);
        advance();
        set_slot(0, 1, OP_STR, 3'd0, 16'h0000, 0);
        set_slot(1, 0, OP_ADD, 3'd0, 16'h0000, 0);
        dmem_resp = 1'b1;
        settle("str_start");
        chk("str_start.cnt_const", 32'(rob_re_count), 32'h0);
        advance();
        settle("str_resp");
        chk("str_resp.ldstr_const", 32'(ldstr_re), 32'h1);
        advance();
        dmem_resp = 1'b0;

        // Invalid head blocks a valid second slot.
        set_slot(0, 0, OP_ADD, 3'd1, 16'h0001, 0);
        set_slot(1, 1, OP_ADD, 3'd2, 16'h0002, 0);
        settle("hole");
        chk("hole.cnt_const", 32'(rob_re_count), 32'h0);
        advance();

        // Reset in the middle of a store wait drops the request at once.
        set_slot(0, 1, OP_STR, 3'd0, 16'h0000, 0);
        set_slot(1, 0, OP_ADD, 3'd0, 16'h0000, 0);
        settle("rst_store0");
        advance();
        settle("rst_store1");
        #1;
        reset_n = 1'b0;
        m_mode = 0; m_cc = 3'b010;
        #1;
        check_all("rst_async");
        chk("rst_async.dw_const", 32'(dmem_write), 32'h0);
        advance();
        reset_n = 1'b1;
        set_slot(0, 1, OP_ADD, 3'd5, 16'h0009, 0);
        settle("rst_release");
        chk("rst_release.cc_const", 32'(cc_out), 32'h2);
        chk("rst_release.we_const", 32'(rf_we), 32'h1);
        advance();

        // Randomized traffic against the model.
        for (int n = 0; n < 500; n++) begin
            for (int k = 0; k < CW; k++) begin
                set_slot(k, ($urandom_range(0, 99) < 85), rand_op(), 3'($urandom),
                         rand_val(), 1'($urandom));
            end
            rob_empty = ($urandom_range(0, 9) == 0);
            dmem_resp = ($urandom_range(0, 99) < 35);
            settle("rand");
            advance();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/commit_unit.md
Name: commit_unit

Overview:
- Multi-wide in-order retirement stage between the reorder buffer head and architectural state (regfile, CC, data memory, fetch redirect).
- Each cycle it examines up to COMMIT_WIDTH head entries and retires an in-order prefix of them.
- It resolves branches against a speculatively chained CC and flushes on misprediction.
- Stores are performed through a request/response handshake with data memory, unlike a single-cycle fire-and-forget write.

Parameters:
DATA_WIDTH, 16, width of result values and PC
TAG_WIDTH, 3, ROB tag width (carried for ld/str buffer compatibility)
COMMIT_WIDTH, 2, ROB head entries examined per cycle (1..4)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
valid_in  in  COMMIT_WIDTH  slot i holds a completed ROB entry (slot 0 = head)
opcode_in  in  4*COMMIT_WIDTH  lc3b_opcode per slot
dest_in  in  3*COMMIT_WIDTH  dest register per slot; nzp mask for op_br
value_in  in  DATA_WIDTH*COMMIT_WIDTH  result per slot; target PC for op_br
predict_in  in  COMMIT_WIDTH  predicted-taken bit per slot
rob_empty  in  1  ROB has no entries
dmem_resp  in  1  data memory store completion
rf_we  out  COMMIT_WIDTH  regfile value write per slot
rf_busy_clr  out  COMMIT_WIDTH  clear busy bit for rf_dest slot i
rf_dest  out  3*COMMIT_WIDTH  copies dest_in
rf_value  out  DATA_WIDTH*COMMIT_WIDTH  copies value_in
rob_re_count  out  $clog2(COMMIT_WIDTH+1)  entries popped this cycle
ldstr_re  out  1  pop one entry from ld/str buffer
dmem_write  out  1  store request, held until dmem_resp
flush  out  1  squash all speculative state
pcmux_sel  out  1  redirect fetch to new_pc
new_pc  out  DATA_WIDTH  redirect target
cc_out  out  3  architectural nzp

Behaviour:
- Reset (async on reset_n low): state IDLE, CC = 3'b010. All strobes (rf_we, rf_busy_clr, rob_re_count, ldstr_re, dmem_write, flush, pcmux_sel) are 0 while reset is asserted.
- Reset mid-store drops the request. dmem_write falls immediately.
- Retire prefix: slots are scanned 0..COMMIT_WIDTH-1. Scanning stops at the first slot that is invalid or has an unsupported opcode. These are never retired, and later slots are ignored. If rob_empty=1, nothing retires.
- Regfile ops (op_add, op_and, op_not, op_shf, op_lea, op_ldr):
  - Retire with rf_we and rf_busy_clr.
  - Update the chained CC: gencc(value) feeds later slots in the same cycle.
  - The CC register loads the last chained value at the clock edge.
- op_jsr: retires with rf_we and rf_busy_clr; no CC effect.
- op_br:
  - taken = |(dest_in & chained CC), where chained CC is the value after earlier same-cycle slots.
  - The branch always retires and always terminates the group.
  - If taken != predict_in: flush=1, pcmux_sel=1, new_pc = value_in of that slot. Earlier slots in the group still commit. The state goes to FLUSH.
  - When no mispredict is active, new_pc is don't-care.
- op_str: a store must be slot 0 to start. A store in slot i>0 terminates the group before it and is handled next cycle. In IDLE with slot 0 a store:
  - Assert dmem_write and go to STORE_WAIT. The store does not retire this cycle.
- STORE_WAIT:
  - dmem_write is held at 1 and no other retirement occurs.
  - On dmem_resp=1: retire the store (rob_re_count=1, ldstr_re=1), deassert dmem_write the next cycle, return to IDLE.
  - dmem_resp in the same cycle as the request (IDLE) is ignored; minimum store latency is 2 cycles.
- FLUSH: lasts exactly one cycle. Nothing retires, all strobes are 0, CC holds. The state then returns to IDLE.
- rob_re_count equals the number of retired slots. rf_we, rf_busy_clr and ldstr_re are asserted only for retired slots.
- Simultaneous events: a mispredict in slot i suppresses all slots >i, including stores.

Test Plan:
- W=2, slots add(value 0x0000, R1) + add(value 0xFFFE, R2) -> rf_we=2'b11, rob_re_count=2, cc_out=3'b100 next cycle.
- Slot0 add value 0x0005, slot1 br nzp=3'b010 predict=1 -> chained CC=3'b001, not taken, so mispredict: flush=1, pcmux_sel=1, new_pc=slot1 value, rob_re_count=2; next cycle all strobes 0.
- Slot0 str, dmem_resp low for 3 cycles then high -> dmem_write high 4 cycles, rob_re_count=1 and ldstr_re=1 only on resp cycle, IDLE after.
- Slot0 jsr (dest R7), slot1 str -> only jsr retires (count=1), store starts next cycle.
- Slot0 valid=0, slot1 valid add -> rob_re_count=0, rf_we=0.
- reset_n low during STORE_WAIT -> dmem_write=0 asynchronously; after release state IDLE, cc_out=3'b010.
